pr_decoder3_8_seq: RTL

- Sequenced 3-to-8 decoder. It accepts encoded indices (3-bit code plus "none" flag) through a valid/ready handshake and buffers them in a small FIFO.
- Each entry is replayed as a one-hot pulse on an 8-bit output for a programmable number of cycles, followed by a programmable idle gap.
- Sits downstream of the 8-to-3 priority encoder: turns its codes back into timed one-hot strobes (channel select, LED/relay drive, interrupt acknowledge).

---
 rtl/pr_codec_pkg.sv | 39 +++
 rtl/pr_codec_fifo.sv | 112 +++++++++++
 rtl/pr_decoder3_8_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pr_codec_pkg.sv
// -----------------------------------------------------------------------------
// pr_codec_pkg
// Shared definitions for the sequenced 3-to-8 decoder slice.
//   - Widths of the encoded index, the one-hot word and one buffered entry.
//   - FSM state encoding used by pr_decoder3_8_seq.
//   - word_of(): maps {none, code} onto the one-hot output word.
// -----------------------------------------------------------------------------
package pr_codec_pkg;

   localparam int CODE_W   = 3;
   localparam int ONEHOT_W = 8;
   localparam int ENTRY_W  = CODE_W + 1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_DRIVE = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   // One buffered entry; 'none' is the MSB so the raw FIFO word reads {none, code}.
   typedef struct packed {
      logic              none;
      logic [CODE_W-1:0] code;
   } entry_t;

   // A "none" entry still occupies a pulse slot but drives no bit.
   function automatic logic [ONEHOT_W-1:0] word_of(input logic              none,
                                                   input logic [CODE_W-1:0] code);
      logic [ONEHOT_W-1:0] word_v;
      word_v = {ONEHOT_W{1'b0}};
      if (none) begin
         word_v = {ONEHOT_W{1'b0}};
      end else begin
         word_v[code] = 1'b1;
      end
      return word_v;
   endfunction

endpackage

// File: rtl/pr_codec_fifo.sv
// -----------------------------------------------------------------------------
// pr_codec_fifo
// Synchronous show-ahead FIFO holding {none, code} entries for the decoder.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   push_i       : write din_i this edge (ignored while full)
//   pop_i        : discard the head entry this edge (ignored while empty)
//   din_i        : entry to store
//   dout_o       : current head entry (valid while !empty_o)
//   count_o      : occupancy, 0..FIFO_DEPTH
//   full_o       : count_o == FIFO_DEPTH
//   empty_o      : count_o == 0
// Full/empty come from the occupancy counter, so the pointers can wrap freely
// without an extra wrap bit.
// -----------------------------------------------------------------------------
module pr_codec_fifo
   import pr_codec_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [ENTRY_W-1:0]            din_i,
   output logic [ENTRY_W-1:0]            dout_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]      wptr_q;
   logic [PW-1:0]      wptr_d;
   logic [PW-1:0]      rptr_q;
   logic [PW-1:0]      rptr_d;
   logic [CW-1:0]      count_q;
   logic [CW-1:0]      count_d;
   logic               full_s;
   logic               empty_s;
   logic               push_ok_s;
   logic               pop_ok_s;

   // Status flags and qualified push/pop strobes.
   always_comb begin
      full_s    = (count_q == CNT_FULL);
      empty_s   = (count_q == CNT_ZERO);
      push_ok_s = push_i && !full_s;
      pop_ok_s  = pop_i && !empty_s;
   end

   // Pointer and occupancy next-state; pointers wrap naturally at 2**PW.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok_s) begin
         wptr_d = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
         rptr_d = rptr_q + PTR_ONE;
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= PTR_ZERO;
         rptr_q  <= PTR_ZERO;
         count_q <= CNT_ZERO;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; cleared on reset so no stale entry can ever be replayed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {ENTRY_W{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_q[wptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = full_s;
   assign empty_o = empty_s;

endmodule

// File: rtl/pr_decoder3_8_seq.sv
// -----------------------------------------------------------------------------
// pr_decoder3_8_seq
// Sequenced 3-to-8 decoder. Encoded indices arrive over valid/ready, are
// buffered in pr_codec_fifo, and are replayed one at a time as a one-hot
// pulse of PULSE_LEN cycles followed by GAP_LEN all-zero cycles.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   code_in     : encoded index 0..7
//   none_in     : entry carries no bit; its pulse slot drives all zeros
//   valid_in    : code_in/none_in offered this cycle
//   ready_out   : buffer can accept (not full)
//   data_out    : registered one-hot word
//   busy_out    : registered, high while a pulse or gap is being played
//   count_out   : buffer occupancy 0..FIFO_DEPTH
// Parameters: PULSE_LEN 1..255, GAP_LEN 0..255, FIFO_DEPTH power of 2, 2..16.
// -----------------------------------------------------------------------------
module pr_decoder3_8_seq
   import pr_codec_pkg::*;
#(
   parameter int PULSE_LEN  = 4,
   parameter int GAP_LEN    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CODE_W-1:0]             code_in,
   input  logic                          none_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   output logic [ONEHOT_W-1:0]           data_out,
   output logic                          busy_out,
   output logic [$clog2(FIFO_DEPTH):0]   count_out
);

   // Counters hold "cycles remaining after this one", hence the -1 reloads.
   localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_RELOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
   localparam bit         HAS_GAP      = (GAP_LEN > 0);

   state_t                 state_q;
   state_t                 state_d;
   logic [7:0]             pcnt_q;
   logic [7:0]             pcnt_d;
   logic [7:0]             gcnt_q;
   logic [7:0]             gcnt_d;
   logic [ONEHOT_W-1:0]    data_q;
   logic [ONEHOT_W-1:0]    data_d;
   logic                   busy_q;
   logic                   busy_d;

   logic                   push_s;
   logic                   pop_s;
   logic                   load_s;
   logic                   full_s;
   logic                   empty_s;
   entry_t                 in_entry_s;
   entry_t                 head_s;
   logic [ENTRY_W-1:0]     head_raw_s;

   assign in_entry_s = {none_in, code_in};
   assign head_s     = entry_t'(head_raw_s);
   assign push_s     = valid_in && !full_s;

   pr_codec_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (in_entry_s),
      .dout_o  (head_raw_s),
      .count_o (count_out),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // State register together with the pulse/gap counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pcnt_q  <= 8'd0;
         gcnt_q  <= 8'd0;
         data_q  <= {ONEHOT_W{1'b0}};
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         gcnt_q  <= gcnt_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; a "load" pops the head entry and starts a new pulse.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      gcnt_d  = gcnt_q;
      pop_s   = 1'b0;
      load_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               load_s  = 1'b1;
               pcnt_d  = PULSE_RELOAD;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (pcnt_q != 8'd0) begin
               pcnt_d = pcnt_q - 8'd1;
            end else if (HAS_GAP) begin
               gcnt_d  = GAP_RELOAD;
               state_d = ST_GAP;
            end else if (!empty_s) begin
               // No gap configured: next word follows back-to-back.
               pop_s   = 1'b1;
               load_s  = 1'b1;
               pcnt_d  = PULSE_RELOAD;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gcnt_q != 8'd0) begin
               gcnt_d = gcnt_q - 8'd1;
            end else if (!empty_s) begin
               pop_s   = 1'b1;
               load_s  = 1'b1;
               pcnt_d  = PULSE_RELOAD;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            // Unused encoding: fall back to a clean idle.
            state_d = ST_IDLE;
            pcnt_d  = 8'd0;
            gcnt_d  = 8'd0;
         end
      endcase
   end

   // Output logic; data is held only while a pulse still has cycles remaining.
   always_comb begin
      data_d = {ONEHOT_W{1'b0}};
      busy_d = (state_d != ST_IDLE);
      if (load_s) begin
         data_d = word_of(head_s.none, head_s.code);
      end else if ((state_q == ST_DRIVE) && (pcnt_q != 8'd0)) begin
         data_d = data_q;
      end else begin
         data_d = {ONEHOT_W{1'b0}};
      end
   end

   assign ready_out = !full_s;
   assign data_out  = data_q;
   assign busy_out  = busy_q;

endmodule
